// File: rtl/switch_ctrl_pkg.sv
// switch_ctrl_pkg: shared scan FSM states and width helpers for switch_scan_ctrl
package switch_ctrl_pkg;
  typedef enum logic [1:0] {WAIT, STROBE, EVAL} scan_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int s);
    return $clog2(s + 1);
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: enable-gated prescaler, one-cycle pulse on terminal count
module scan_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);
  localparam int W = $clog2(PRESCALE);
  logic [W-1:0] r_pcnt;
  assign o_tick = i_enable && (r_pcnt == W'(PRESCALE - 1));
  always_ff @(posedge i_clk) begin
    if (i_reset) r_pcnt <= '0;
    else if (i_enable) r_pcnt <= o_tick ? '0 : r_pcnt + 1'b1;
  end
endmodule

// File: rtl/switch_scan_ctrl.sv
// switch_scan_ctrl: round-robin switch strobe scheduler with per-channel debounce.
// SWITCH_SCAN_EVENT_EN enables the valid/ready event port and commit deferral.
module switch_scan_ctrl
  import switch_ctrl_pkg::*;
#(
  parameter int N_SWITCHES   = 8,
  parameter int PRESCALE     = 50000,
  parameter int STABLE_COUNT = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_enable,
  output logic [N_SWITCHES-1:0]         o_sample,
  input  logic [N_SWITCHES-1:0]         i_switch,
  output logic [N_SWITCHES-1:0]         o_state,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [$clog2(N_SWITCHES)-1:0] o_evt_index,
  output logic                          o_evt_level
);
  localparam int IW = idx_w(N_SWITCHES);
  localparam int CW = cnt_w(STABLE_COUNT);
`ifdef SWITCH_SCAN_EVENT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif
  scan_state_e           r_fsm, w_fsm_nxt;
  logic [IW-1:0]         r_idx, r_evt_idx;
  logic [CW-1:0]         r_dcnt [N_SWITCHES];
  logic [N_SWITCHES-1:0] r_state;
  logic                  r_valid, r_level;
  logic                  w_tick, w_eval, w_samp, w_diff, w_ripe, w_full, w_commit;
  logic [CW-1:0]         w_dcnt;

  scan_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_enable(i_enable),
    .o_tick  (w_tick)
  );

  assign w_eval   = r_fsm == EVAL;
  assign w_samp   = i_switch[r_idx];
  assign w_dcnt   = r_dcnt[r_idx];
  assign w_diff   = w_samp != r_state[r_idx];
  assign w_ripe   = int'(w_dcnt) + 1 >= STABLE_COUNT;
  // A ripe change waits at STABLE_COUNT-1 while an unaccepted event occupies the slot
  assign w_full   = EVT_EN && r_valid && !i_evt_ready;
  assign w_commit = w_eval && w_diff && w_ripe && !w_full;

  always_comb begin
    w_fsm_nxt = (r_fsm == STROBE) ? EVAL : (w_tick ? STROBE : WAIT);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_fsm <= WAIT;
    else r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx     <= '0;
      r_state   <= '0;
      r_valid   <= 1'b0;
      r_evt_idx <= '0;
      r_level   <= 1'b0;
      for (int k = 0; k < N_SWITCHES; k++) r_dcnt[k] <= '0;
    end else begin
      r_valid <= EVT_EN && (w_commit || (r_valid && !i_evt_ready));
      if (w_eval) begin
        r_idx         <= (r_idx == IW'(N_SWITCHES - 1)) ? '0 : r_idx + 1'b1;
        r_dcnt[r_idx] <= !w_diff ? '0 : !w_ripe ? w_dcnt + 1'b1 : w_full ? CW'(STABLE_COUNT - 1) : '0;
      end
      if (w_commit) begin
        r_state[r_idx] <= w_samp;
        r_evt_idx      <= r_idx;
        r_level        <= w_samp;
      end
    end
  end

  assign o_sample    = (r_fsm == STROBE) ? N_SWITCHES'(1) << r_idx : '0;
  assign o_state     = r_state;
  assign o_evt_valid = r_valid;
  assign o_evt_index = EVT_EN ? r_evt_idx : '0;
  assign o_evt_level = EVT_EN && r_level;
endmodule

// File: tb/tb_switch_scan_ctrl.sv
// tb_switch_scan_ctrl: directed self-checking bench, N_SWITCHES=4 PRESCALE=4 STABLE_COUNT=3
module tb_switch_scan_ctrl;
`ifdef SWITCH_SCAN_EVENT_EN
  localparam bit EVT = 1'b1;
`else
  localparam bit EVT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst, en, ready;
  logic [3:0] sw, sample, state;
  logic       valid, level;
  logic [1:0] eidx;
  int         passed = 0;
  int         total = 0;

  switch_scan_ctrl #(.N_SWITCHES(4), .PRESCALE(4), .STABLE_COUNT(3)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_enable   (en),
    .o_sample   (sample),
    .i_switch   (sw),
    .o_state    (state),
    .o_evt_valid(valid),
    .i_evt_ready(ready),
    .o_evt_index(eidx),
    .o_evt_level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b1; sw = '0; ready = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_strobe(input int ch);
    int n = 0;
    while (sample !== 4'(1 << ch) && n < 100) begin
      tick;
      n++;
    end
    total++;
    if (n >= 100) $display("FAIL strobe_wait ch%0d: no strobe seen, got %b required %b", ch, sample, 4'(1 << ch));
    else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; sw = 4'hF; ready = 1'b0;
    tick;
    total++;
    if ({sample, state, valid, eidx, level} !== 12'h0)
      $display("FAIL reset_state: got sample=%b state=%b valid=%b idx=%0d level=%b required all 0", sample, state, valid, eidx, level);
    else passed++;
  endtask

  task automatic test_scan_order;
    logic [3:0] exp;
    do_reset;
    for (int k = 1; k <= 20; k++) begin
      tick;
      exp = (k % 4 == 0) ? 4'(1 << ((k / 4 - 1) % 4)) : 4'b0;
      total++;
      if (sample !== exp) $display("FAIL scan_order cycle %0d: got %b required %b", k, sample, exp);
      else passed++;
    end
  endtask

  task automatic test_debounce_commit;
    do_reset;
    sw[2] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_strobe(2);
      tick;
      tick;
      total++;
      if (state !== ((r == 2) ? 4'b0100 : 4'b0000)) $display("FAIL commit_state pass %0d: got %b required %b", r, state, (r == 2) ? 4'b0100 : 4'b0000);
      else passed++;
      total++;
      if (valid !== (r == 2 && EVT)) $display("FAIL commit_valid pass %0d: got %b required %b", r, valid, (r == 2 && EVT));
      else passed++;
    end
    if (EVT) begin
      total++;
      if ({eidx, level} !== 3'b101) $display("FAIL commit_event: got idx=%0d level=%b required idx=2 level=1", eidx, level);
      else passed++;
    end
    tick;
    total++;
    if (valid !== 1'b0) $display("FAIL commit_valid_drop: got %b required 0", valid);
    else passed++;
  endtask

  task automatic test_glitch_reject;
    logic vals [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset;
    for (int r = 0; r < 6; r++) begin
      sw[1] = vals[r];
      wait_strobe(1);
      tick;
      tick;
      total++;
      if (state[1] !== (r == 5)) $display("FAIL glitch_state sample %0d: got %b required %b", r, state[1], (r == 5));
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    ready = 1'b0;
    sw = 4'b1001;
    for (int r = 0; r < 3; r++) begin
      wait_strobe(0);
      tick;
      tick;
    end
    total++;
    if (state !== 4'b0001 || valid !== EVT) $display("FAIL bp_ch0: got state=%b valid=%b required state=0001 valid=%b", state, valid, EVT);
    else passed++;
    wait_strobe(3);
    tick;
    tick;
    total++;
    if (state !== (EVT ? 4'b0001 : 4'b1001)) $display("FAIL bp_defer_state: got %b required %b", state, EVT ? 4'b0001 : 4'b1001);
    else passed++;
    if (EVT) begin
      total++;
      if (valid !== 1'b1 || eidx !== 2'd0) $display("FAIL bp_hold: got valid=%b idx=%0d required valid=1 idx=0", valid, eidx);
      else passed++;
    end
    ready = 1'b1;
    tick;
    ready = 1'b0;
    total++;
    if (valid !== 1'b0) $display("FAIL bp_release: got valid=%b required 0", valid);
    else passed++;
    wait_strobe(3);
    tick;
    tick;
    total++;
    if (state !== 4'b1001 || valid !== EVT) $display("FAIL bp_retry: got state=%b valid=%b required state=1001 valid=%b", state, valid, EVT);
    else passed++;
    if (EVT) begin
      total++;
      if ({eidx, level} !== 3'b111) $display("FAIL bp_retry_event: got idx=%0d level=%b required idx=3 level=1", eidx, level);
      else passed++;
    end
    ready = 1'b1;
  endtask

  task automatic test_enable_hold;
    do_reset;
    tick;
    tick;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      total++;
      if (sample !== 4'b0) $display("FAIL enable_hold cycle %0d: got %b required 0000", k, sample);
      else passed++;
    end
    en = 1'b1;
    tick;
    total++;
    if (sample !== 4'b0) $display("FAIL enable_resume_early: got %b required 0000", sample);
    else passed++;
    tick;
    total++;
    if (sample !== 4'b0001) $display("FAIL enable_resume_strobe: got %b required 0001", sample);
    else passed++;
  endtask

  task automatic test_reset_midop;
    do_reset;
    ready = 1'b0;
    sw[2] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_strobe(2);
      tick;
      tick;
    end
    total++;
    if (state !== 4'b0100 || valid !== EVT) $display("FAIL midop_pre: got state=%b valid=%b required state=0100 valid=%b", state, valid, EVT);
    else passed++;
    rst = 1'b1;
    sw = '0;
    tick;
    total++;
    if ({sample, state, valid, eidx, level} !== 12'h0)
      $display("FAIL midop_reset: got sample=%b state=%b valid=%b idx=%0d level=%b required all 0", sample, state, valid, eidx, level);
    else passed++;
    rst = 1'b0;
    ready = 1'b1;
    repeat (3) tick;
    total++;
    if (sample !== 4'b0) $display("FAIL midop_gap: got %b required 0000", sample);
    else passed++;
    tick;
    total++;
    if (sample !== 4'b0001) $display("FAIL midop_first_strobe: got %b required 0001", sample);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_scan_order;
    test_debounce_commit;
    test_glitch_reject;
    test_backpressure;
    test_enable_hold;
    test_reset_midop;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
